// File: rtl/morse_pkg.sv
// Shared types, unit lengths and the hex-to-Morse code ROM for morse_tx.
package morse_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_CHAR_GAP
  } state_e;

  localparam logic [1:0] DOT_UNITS      = 2'd1;
  localparam logic [1:0] DASH_UNITS     = 2'd3;
  localparam logic [1:0] ELEM_GAP_UNITS = 2'd1;
  localparam logic [1:0] CHAR_GAP_UNITS = 2'd3;

  // Returns {len[2:0], pat[4:0]}; pattern is left-aligned, bit 4 = first element, 1 = dash.
  function automatic logic [7:0] code_rom(input logic [3:0] sym);
    logic [7:0] c;
    case (sym)
      4'h0:    c = {3'd5, 5'b11111};
      4'h1:    c = {3'd5, 5'b01111};
      4'h2:    c = {3'd5, 5'b00111};
      4'h3:    c = {3'd5, 5'b00011};
      4'h4:    c = {3'd5, 5'b00001};
      4'h5:    c = {3'd5, 5'b00000};
      4'h6:    c = {3'd5, 5'b10000};
      4'h7:    c = {3'd5, 5'b11000};
      4'h8:    c = {3'd5, 5'b11100};
      4'h9:    c = {3'd5, 5'b11110};
      4'hA:    c = {3'd2, 5'b01000};
      4'hB:    c = {3'd4, 5'b10000};
      4'hC:    c = {3'd4, 5'b10100};
      4'hD:    c = {3'd3, 5'b10000};
      4'hE:    c = {3'd1, 5'b00000};
      default: c = {3'd4, 5'b00100};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler for morse_tx: one-cycle unit_tick_o every UNIT_CYCLES clocks, restarted by clr_i.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic unit_tick_o
);

  localparam int CW = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)             cnt_q <= '0;
    else if (clr_i)         cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + 1'b1;
  end

  assign unit_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/morse_tx.sv
// Hex key value to timed Morse tone. Optional abort input enabled by MORSE_TX_ABORT_EN.
//   state      | meaning
//   S_IDLE     | ready, waiting for a symbol
//   S_MARK     | tone on, one dot or dash
//   S_SPACE    | 1-unit gap between elements
//   S_CHAR_GAP | 3-unit gap closing the character
module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef MORSE_TX_ABORT_EN
  input  logic       abort,
`endif
  input  logic       sym_valid,
  input  logic [3:0] sym_data,
  output logic       sym_ready,
  output logic       tone,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [2:0] len_q, len_d;
  logic [4:0] pat_q, pat_d;
  logic [2:0] elem_q, elem_d;
  logic [1:0] unit_q, unit_d;
  logic       tone_q, tone_d;
  logic       done_q, done_d;
  logic [1:0] need;
  logic       unit_tick;
  logic       units_done;
  logic       state_chg;
  logic       abort_w;

`ifdef MORSE_TX_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    need = CHAR_GAP_UNITS;
    case (state_q)
      S_MARK:  need = pat_q[4] ? DASH_UNITS : DOT_UNITS;
      S_SPACE: need = ELEM_GAP_UNITS;
      default: need = CHAR_GAP_UNITS;
    endcase
  end

  assign units_done = unit_tick && (unit_q == need - 2'd1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pat_d   = pat_q;
    elem_d  = elem_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sym_valid) begin
          {len_d, pat_d} = code_rom(sym_data);
          elem_d  = 3'd0;
          state_d = S_MARK;
        end
      end
      S_MARK: begin
        if (units_done) begin
          pat_d   = {pat_q[3:0], 1'b0};
          elem_d  = elem_q + 3'd1;
          state_d = (elem_q == len_q - 3'd1) ? S_CHAR_GAP : S_SPACE;
        end
      end
      S_SPACE: begin
        if (units_done) state_d = S_MARK;
      end
      default: begin
        if (units_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
    // Abort only affects an active character; an accept in IDLE takes priority.
    if (abort_w && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  assign state_chg = (state_d != state_q);
  assign unit_d    = state_chg ? 2'd0 : (unit_tick ? unit_q + 2'd1 : unit_q);
  assign tone_d    = (state_d == S_MARK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pat_q   <= '0;
      elem_q  <= '0;
      unit_q  <= '0;
      tone_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      elem_q  <= elem_d;
      unit_q  <= unit_d;
      tone_q  <= tone_d;
      done_q  <= done_d;
    end
  end

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (state_chg || state_q == S_IDLE),
    .unit_tick_o (unit_tick)
  );

  assign sym_ready = (state_q == S_IDLE);
  assign busy      = ~sym_ready;
  assign tone      = tone_q;
  assign done      = done_q;

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with UNIT_CYCLES = 4; tone run-lengths are hand-computed.
`timescale 1ns/1ps
module tb_morse_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic       sym_valid;
  logic [3:0] sym_data;
  logic       sym_ready, tone, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  morse_tx #(.UNIT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MORSE_TX_ABORT_EN
    .abort     (abort),
`endif
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .sym_ready (sym_ready),
    .tone      (tone),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at the negedge of cycle 1 after accept; returns at the negedge of the done cycle.
  task automatic measure(input bit noise, output logic [79:0] runs, output int hi,
                         output int busy_n, output int done_cyc, output logic saw_done);
    logic cur;
    int   len;
    cur = 1'b1; len = 0; runs = '0; hi = 0; busy_n = 0; done_cyc = 0; saw_done = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (!busy) begin
        done_cyc = c;
        saw_done = done;
        if (noise) sym_valid = 1'b0;
        break;
      end
      busy_n++;
      if (tone) hi++;
      if (tone == cur) len++;
      else begin
        runs = (runs << 8) | 80'(len);
        cur  = tone;
        len  = 1;
      end
      if (noise) begin
        sym_data  = 4'($urandom_range(0, 15));
        sym_valid = c[1];
      end
      @(negedge clk);
    end
    runs = (runs << 8) | 80'(len);
  endtask

  task automatic send(input logic [3:0] d);
    sym_valid = 1'b1;
    sym_data  = d;
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  logic [79:0] runs;
  int          hi, bn, dc, cnt;
  logic        sd;

  initial begin
    rst_n = 1'b0; abort = 1'b0; sym_valid = 1'b0; sym_data = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_tone",  tone, 1'b0);
    check("rst_ready", sym_ready, 1'b1);
    check("rst_busy",  busy, 1'b0);
    check("rst_done",  done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // E: 4 high, 12 low, done at 17
    send(4'hE);
    measure(1'b0, runs, hi, bn, dc, sd);
    check("E_runs", runs, {8'd4, 8'd12});
    check("E_hi", hi, 4);
    check("E_busy", bn, 16);
    check("E_done_cyc", dc, 17);
    check("E_done", sd, 1'b1);
    @(negedge clk);
    check("E_done_pulse", done, 1'b0);

    // 0: five dashes, done at 89
    send(4'h0);
    measure(1'b0, runs, hi, bn, dc, sd);
    check("0_runs", runs, {8'd12, 8'd4, 8'd12, 8'd4, 8'd12, 8'd4, 8'd12, 8'd4, 8'd12, 8'd12});
    check("0_hi", hi, 60);
    check("0_done_cyc", dc, 89);
    check("0_done", sd, 1'b1);
    @(negedge clk);

    // A then B with valid held
    sym_valid = 1'b1; sym_data = 4'hA;
    @(negedge clk);
    sym_data = 4'hB;
    measure(1'b0, runs, hi, bn, dc, sd);
    check("A_runs", runs, {8'd4, 8'd4, 8'd12, 8'd12});
    check("A_busy", bn, 32);
    check("A_ready_at_done", sym_ready, 1'b1);
    @(negedge clk);
    sym_valid = 1'b0;
    check("B_accepted", busy, 1'b1);
    measure(1'b0, runs, hi, bn, dc, sd);
    check("B_runs", runs, {8'd12, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd12});
    check("B_done_cyc", dc, 49);
    @(negedge clk);

    // Reset in cycle 10 of '5'
    send(4'h5);
    repeat (9) @(negedge clk);
    check("5_busy_c10", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_tone",  tone, 1'b0);
    check("rstmid_ready", sym_ready, 1'b1);
    check("rstmid_done",  done, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("rstmid_quiet", cnt, 0);
    send(4'h1);
    measure(1'b0, runs, hi, bn, dc, sd);
    check("1_runs", runs, {8'd4, 8'd4, 8'd12, 8'd4, 8'd12, 8'd4, 8'd12, 8'd4, 8'd12, 8'd12});
    check("1_done_cyc", dc, 81);
    @(negedge clk);

    // D with sym_data/sym_valid noise while busy
    send(4'hD);
    measure(1'b1, runs, hi, bn, dc, sd);
    check("D_runs", runs, {8'd12, 8'd4, 8'd4, 8'd4, 8'd4, 8'd12});
    check("D_done_cyc", dc, 41);
    @(negedge clk);
    check("D_no_extra_accept", busy, 1'b0);

`ifdef MORSE_TX_ABORT_EN
    // Abort in cycle 6 of C
    send(4'hC);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_tone",  tone, 1'b0);
    check("abort_ready", sym_ready, 1'b1);
    check("abort_done",  done, 1'b0);
    // Abort coincident with accept: character is still sent
    abort = 1'b1;
    send(4'hE);
    abort = 1'b0;
    measure(1'b0, runs, hi, bn, dc, sd);
    check("abort_accept_runs", runs, {8'd4, 8'd12});
    check("abort_accept_done", sd, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
# morse_tx

Morse transmitter for the hex keypad path. Accepts one 4-bit key value (0–F) per valid/ready handshake, looks up its Morse pattern, and drives a timed on/off `tone` line for the buzzer or LED. It sits downstream of the keypad scanner: the scanner turns key presses into values, and this block turns values back into Morse timing. The pattern is timed in fixed units derived from `clk`.

## Interface
- `UNIT_CYCLES`, default 12_500_000: clk cycles per Morse unit (125 ms at 100 MHz); legal ≥ 2; benches use 4.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low; clock clk.
- `sym_valid`  in  1  `sym_data` holds a symbol to send.
- `sym_data`  in  4  key value 0x0–0xF.
- `sym_ready`  out  1  block idle; accepts a symbol this cycle.
- `tone`  out  1  1 = mark (key down), 0 = space.
- `busy`  out  1  equals `!sym_ready`.
- `done`  out  1  one-cycle pulse when a character, including its trailing gap, has completed.
- `abort`  in  1  present only with `MORSE_TX_ABORT_EN`.

## Operation
- Code table, element order first→last, 1 = dash:
  - 0 `-----`, 1 `.----`, 2 `..---`, 3 `...--`, 4 `....-`
  - 5 `.....`, 6 `-....`, 7 `--...`, 8 `---..`, 9 `----.`
  - A `.-`, B `-...`, C `-.-.`, D `-..`, E `.`, F `..-.`
- Table encoding is 3-bit length (1..5) plus 5-bit pattern, MSB = first element.
- States:
  - IDLE → MARK on accept.
  - MARK → SPACE if elements remain, else CHAR_GAP.
  - SPACE → MARK.
  - CHAR_GAP → IDLE.
- Unit lengths: dot MARK 1 unit; dash MARK 3 units; SPACE 1 unit; CHAR_GAP 3 units.
- Accept occurs when `sym_valid && sym_ready`. `sym_data` is latched at that edge and ignored at all other times. `sym_ready` is 1 only in IDLE.
- `tone` = 1 only in MARK. It is registered and glitch-free.
- `done` is asserted in the first IDLE cycle after CHAR_GAP.
- `valid` held continuously: back-to-back characters are separated by exactly the 3-unit CHAR_GAP plus one IDLE accept cycle.
- Reset values: `tone` 0, `sym_ready` 1, `busy` 0, `done` 0, state IDLE, all counters 0.
- Reset mid-character: the next cycle is IDLE with `tone` 0; no `done` is issued.
- Arithmetic:
  - cycle counter width `$clog2(UNIT_CYCLES)`; counts 0..UNIT_CYCLES-1 and wraps, producing a unit tick.
  - unit counter 2 bits (0..2).
  - element index 3 bits.
  - No overflow is possible for legal parameters.

## Timing
- Accept at edge 0: `tone` is high from cycle 1.
- Busy length per character, in units: sum of marks + (n-1) spaces + 3.
  - E = 4 units; 5 = 12; 0 = 22; A = 8.
- With U = UNIT_CYCLES, for E: `tone` = 1 in cycles 1..U; 0 in cycles U+1..4U. Cycle 4U+1: `sym_ready` = 1 and `done` = 1.
- `sym_ready` drops in cycle 1 after accept. Zero-latency turnaround is not supported: IDLE always lasts at least 1 cycle.

## Configuration
- `MORSE_TX_ABORT_EN` defined:
  - Adds input `abort`. Sampled high in any non-IDLE state, the next cycle is IDLE with `tone` 0, `sym_ready` 1, `done` 0.
  - Abort in IDLE is ignored.
  - Abort and accept in the same cycle (IDLE): accept wins.
- Not defined: port absent; behaviour as above.

## Structure
- Package `morse_pkg`:
  - state enum;
  - `DOT_UNITS` = 1, `DASH_UNITS` = 3, `ELEM_GAP_UNITS` = 1, `CHAR_GAP_UNITS` = 3;
  - 16-entry code ROM constant/function returning {len[2:0], pat[4:0]}.
- Sub-module `morse_unit_timer`: parameterised prescaler producing a 1-cycle `unit_tick`, cleared on state entry so every interval is exactly N×UNIT_CYCLES.

## Test plan
All scenarios use UNIT_CYCLES = 4.
- Send E → `tone` high cycles 1–4, low 5–16; `done` and `sym_ready` at cycle 17; `busy` high cycles 1–16.
- Send 0 → five 12-cycle marks separated by 4-cycle spaces; 60 high cycles total; `done` at cycle 89.
- Send A then B with `sym_valid` held → A busy 32 cycles; B accepted in first IDLE cycle; B `tone` = 12 high, 4 low, then 4/4/4/4/4 (dash, then three dot/space pairs), then 12-cycle gap.
- Assert reset at cycle 10 of sending 5 → `tone` 0 the next cycle, `sym_ready` 1, no `done`; a following send of 1 is timed correctly.
- `sym_data` toggling while busy and `sym_valid` pulsing → no extra accepts; pattern matches the originally latched value.
- With `MORSE_TX_ABORT_EN`, abort at cycle 6 of C → next cycle `tone` 0, `sym_ready` 1, `done` 0; abort coincident with accept in IDLE → character is sent.
